chess_clock_core: RTL and testbench
===================================

Name: chess_clock_core

Overview:
- Countdown engine of the two-player chess timer on the Nexys 4.
- Keeps each player's remaining minutes and seconds and runs only the active player's clock, stepping it once per second.
- Handles turn switching, pause/resume and time-out (flag).
- Sits directly upstream of the LCD multiplexing/display stage; its registered min/sec outputs feed that stage.

Parameters:
- CLK_HZ, 100000000, input clock cycles per one-second tick; bench uses a small value, e.g. 4.
- START_MIN, 5, minutes loaded per player at reset/clear; legal range 1..63.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: synchronous, active-low.
- btn_p1  in  1  player-1 "end my turn" press; debounced, one-cycle pulse.
- btn_p2  in  1  player-2 "end my turn" press; debounced, one-cycle pulse.
- btn_pause  in  1  pause/resume toggle; one-cycle pulse.
- clr  in  1  reload both clocks and return to IDLE; one-cycle pulse.
- min1  out  6  player-1 minutes, binary 0..63.
- seg1  out  6  player-1 seconds, binary 0..59.
- min2  out  6  player-2 minutes.
- seg2  out  6  player-2 seconds.
- active  out  2  which clock is running: 01 = P1, 10 = P2, 00 = none.
- paused  out  1  high while in PAUSE.
- flag1  out  1  player-1 time expired (sticky).
- flag2  out  1  player-2 time expired (sticky).

Behaviour:
- All outputs registered; every update is visible the cycle after its cause.
- Reset (rst_n=0 at a clock edge), from any state, including mid-run or mid-pause: min1=min2=START_MIN, seg1=seg2=0, active=00, paused=0, flags=0, prescaler=0, state IDLE.
- clr has the same effect as reset. Priority order: rst_n > clr > everything else.
- Prescaler:
  - Counts 0..CLK_HZ-1 only in RUN_P1/RUN_P2.
  - tick = (count==CLK_HZ-1); on tick the count wraps to 0.
  - Held in PAUSE; cleared on every turn switch.
- Decrement of the active player on tick:
  - sec>0 → sec-1.
  - sec==0, min>0 → min-1, sec=59.
  - Reaching 0:00 → that flag=1, state FLAG.
- States:
  - IDLE: btn_p1 → RUN_P2; btn_p2 → RUN_P1 (pressing your own button starts the opponent). Both buttons together → ignored. btn_pause ignored.
  - RUN_P1 (active=01):
    - btn_p1 → RUN_P2, prescaler=0.
    - btn_p2 ignored.
    - btn_pause → PAUSE, P1 remembered as the resume target.
  - RUN_P2 (active=10): symmetric to RUN_P1.
  - PAUSE (paused=1, active=00):
    - btn_pause → back to the remembered RUN state, prescaler resumes from its held value.
    - Player buttons ignored.
  - FLAG (active=00): all times and flags frozen; only rst_n/clr leave it.
- Simultaneous events:
  - Tick plus a switch in the same cycle: the old active player is decremented first, then the switch happens.
  - If that decrement reaches 0:00 → FLAG; the switch is discarded.
  - Tick plus btn_pause: decrement applied, then PAUSE.
  - btn_pause plus a valid switch: the switch wins; the pause is ignored that cycle.
- Widths:
  - Prescaler width = $clog2(CLK_HZ).
  - No arithmetic wraps below 0:00, because FLAG stops the count.

Decomposition:
- Shared package chess_pkg holds:
  - state enum (IDLE, RUN_P1, RUN_P2, PAUSE, FLAG);
  - SEC_MAX=59;
  - TIME_W=6;
  - ACTIVE_* codes.
- One natural sub-module, player_clock, instantiated twice:
  - inputs: load, dec;
  - outputs: min, sec, zero (asserted when the next dec reaches 0:00).
- Prescaler and FSM stay in chess_clock_core.

Test Plan (CLK_HZ=4, START_MIN=1):
1. Reset released → min1=min2=1, seg1=seg2=0, active=00, paused=0, flag1=flag2=0. Buttons pulsed together in IDLE → no change.
2. btn_p2 pulse in IDLE → active=01 next cycle. After 4 cycles min1=0, seg1=59; min2/seg2 unchanged at 1:00.
3. In RUN_P1, btn_p1 two cycles into the prescaler → active=10, prescaler=0. P2 first shows 0:59 exactly 4 cycles after the switch; P1 frozen.
4. btn_pause in RUN_P2, hold 20 cycles → paused=1, active=00, no time change. btn_pause again → active=10, next P2 decrement occurs after the remaining prescaler cycles.
5. Run P1 from 1:00 for 240 cycles → min1=0, seg1=0, flag1=1, active=00. btn_p1/btn_pause then ignored. clr → 1:00/1:00, flag1=0, IDLE.
6. btn_p1 coincident with the tick that takes P1 0:01→0:00 → flag1=1, FLAG, no switch. Separately, rst_n=0 mid-run → full reload on the next edge.

Source files
------------

// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared types and constants for the chess clock core
package chess_pkg;

    localparam int TIME_W  = 6;
    localparam int SEC_MAX = 59;

    localparam logic [1:0] ACTIVE_NONE = 2'b00;
    localparam logic [1:0] ACTIVE_P1   = 2'b01;
    localparam logic [1:0] ACTIVE_P2   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_P1,
        S_RUN_P2,
        S_PAUSE,
        S_FLAG
    } state_e;

endpackage

// File: rtl/player_clock.sv
// rtl/player_clock.sv - one player's minutes:seconds countdown register
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (reloads START_MIN:00)
//   load        reload START_MIN:00 (wins over dec)
//   dec         step the time down by one second
//   min, sec    registered remaining time
//   zero        high when the next dec lands on 0:00
module player_clock
    import chess_pkg::*;
#(
    parameter int START_MIN = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              dec,
    output logic [TIME_W-1:0] min,
    output logic [TIME_W-1:0] sec,
    output logic              zero
);

    logic [TIME_W-1:0] min_q, min_d;
    logic [TIME_W-1:0] sec_q, sec_d;

    always_comb begin
        min_d = min_q;
        sec_d = sec_q;
        if (load) begin
            min_d = TIME_W'(START_MIN);
            sec_d = '0;
        end else if (dec) begin
            if (sec_q != '0) begin
                sec_d = sec_q - TIME_W'(1);
            end else if (min_q != '0) begin
                min_d = min_q - TIME_W'(1);
                sec_d = TIME_W'(SEC_MAX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_q <= TIME_W'(START_MIN);
            sec_q <= '0;
        end else begin
            min_q <= min_d;
            sec_q <= sec_d;
        end
    end

    assign min  = min_q;
    assign sec  = sec_q;
    assign zero = (min_q == '0) && (sec_q == TIME_W'(1));

endmodule

// File: rtl/chess_clock_core.sv
// rtl/chess_clock_core.sv - two-player chess timer countdown engine
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   btn_p1, btn_p2              "end my turn" pulses
//   btn_pause                   pause/resume toggle pulse
//   clr                         reload both clocks and go idle
//   min1/seg1, min2/seg2        registered remaining time per player
//   active                      01 = P1 running, 10 = P2 running, 00 = none
//   paused                      high while paused
//   flag1, flag2                sticky time-expired flags
module chess_clock_core
    import chess_pkg::*;
#(
    parameter int CLK_HZ    = 100000000,
    parameter int START_MIN = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_p1,
    input  logic              btn_p2,
    input  logic              btn_pause,
    input  logic              clr,
    output logic [TIME_W-1:0] min1,
    output logic [TIME_W-1:0] seg1,
    output logic [TIME_W-1:0] min2,
    output logic [TIME_W-1:0] seg2,
    output logic [1:0]        active,
    output logic              paused,
    output logic              flag1,
    output logic              flag2
);

    localparam int            PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          resume_p2_q, resume_p2_d;   // RUN state to return to from PAUSE
    logic [1:0]    active_q, active_d;
    logic          paused_q, paused_d;
    logic          flag1_q, flag1_d;
    logic          flag2_q, flag2_d;

    logic tick;
    logic dec1, dec2;
    logic zero1, zero2;

    assign tick = ((state_q == S_RUN_P1) || (state_q == S_RUN_P2)) && (presc_q == PRE_LAST);
    assign dec1 = tick && (state_q == S_RUN_P1);
    assign dec2 = tick && (state_q == S_RUN_P2);

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        resume_p2_d = resume_p2_q;
        flag1_d     = flag1_q;
        flag2_d     = flag2_q;

        if (clr) begin
            state_d     = S_IDLE;
            presc_d     = '0;
            resume_p2_d = 1'b0;
            flag1_d     = 1'b0;
            flag2_d     = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (btn_p1 && !btn_p2) begin
                        state_d = S_RUN_P2;
                        presc_d = '0;
                    end else if (btn_p2 && !btn_p1) begin
                        state_d = S_RUN_P1;
                        presc_d = '0;
                    end
                end
                // Order inside RUN: the tick's decrement lands first; reaching
                // 0:00 discards any switch/pause, and a switch beats a pause.
                S_RUN_P1: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick && zero1) begin
                        state_d = S_FLAG;
                        flag1_d = 1'b1;
                    end else if (btn_p1) begin
                        state_d = S_RUN_P2;
                        presc_d = '0;
                    end else if (btn_pause) begin
                        state_d     = S_PAUSE;
                        resume_p2_d = 1'b0;
                    end
                end
                S_RUN_P2: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick && zero2) begin
                        state_d = S_FLAG;
                        flag2_d = 1'b1;
                    end else if (btn_p2) begin
                        state_d = S_RUN_P1;
                        presc_d = '0;
                    end else if (btn_pause) begin
                        state_d     = S_PAUSE;
                        resume_p2_d = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (btn_pause) begin
                        state_d = resume_p2_q ? S_RUN_P2 : S_RUN_P1;
                    end
                end
                S_FLAG: begin
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Status outputs are registered from the next state so they line up
        // with the time registers.
        active_d = ACTIVE_NONE;
        if (state_d == S_RUN_P1) begin
            active_d = ACTIVE_P1;
        end else if (state_d == S_RUN_P2) begin
            active_d = ACTIVE_P2;
        end
        paused_d = (state_d == S_PAUSE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            resume_p2_q <= 1'b0;
            active_q    <= ACTIVE_NONE;
            paused_q    <= 1'b0;
            flag1_q     <= 1'b0;
            flag2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            resume_p2_q <= resume_p2_d;
            active_q    <= active_d;
            paused_q    <= paused_d;
            flag1_q     <= flag1_d;
            flag2_q     <= flag2_d;
        end
    end

    player_clock #(
        .START_MIN (START_MIN)
    ) u_p1 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (clr),
        .dec   (dec1),
        .min   (min1),
        .sec   (seg1),
        .zero  (zero1)
    );

    player_clock #(
        .START_MIN (START_MIN)
    ) u_p2 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (clr),
        .dec   (dec2),
        .min   (min2),
        .sec   (seg2),
        .zero  (zero2)
    );

    assign active = active_q;
    assign paused = paused_q;
    assign flag1  = flag1_q;
    assign flag2  = flag2_q;

endmodule

// File: tb/tb_chess_clock_core.sv
// tb/tb_chess_clock_core.sv - scoreboard bench for chess_clock_core
module tb_chess_clock_core;

    localparam int HZ = 4;
    localparam int SM = 1;

    logic       clk = 1'b0;
    logic       rst_n, btn_p1, btn_p2, btn_pause, clr;
    logic [5:0] min1, seg1, min2, seg2;
    logic [1:0] active;
    logic       paused, flag1, flag2;

    always #5 clk = ~clk;

    chess_clock_core #(
        .CLK_HZ    (HZ),
        .START_MIN (SM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_p1    (btn_p1),
        .btn_p2    (btn_p2),
        .btn_pause (btn_pause),
        .clr       (clr),
        .min1      (min1),
        .seg1      (seg1),
        .min2      (min2),
        .seg2      (seg2),
        .active    (active),
        .paused    (paused),
        .flag1     (flag1),
        .flag2     (flag2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: whole seconds remaining per player.
    // m_st: 0 idle, 1 run P1, 2 run P2, 3 pause, 4 flag
    int m_st, m_pre, m_t1, m_t2, m_res;
    bit m_f1, m_f2;
    logic [31:0] exp_q[$];

    localparam logic [31:0] RELOADED = {4'b0, 6'd1, 6'd0, 6'd1, 6'd0, 2'b00, 1'b0, 1'b0, 1'b0};

    function automatic logic [31:0] model_pack();
        logic [1:0] act;
        act = (m_st == 1) ? 2'b01 : (m_st == 2) ? 2'b10 : 2'b00;
        return {4'b0, 6'(m_t1 / 60), 6'(m_t1 % 60), 6'(m_t2 / 60), 6'(m_t2 % 60),
                act, (m_st == 3), m_f1, m_f2};
    endfunction

    function automatic logic [31:0] dut_pack();
        return {4'b0, min1, seg1, min2, seg2, active, paused, flag1, flag2};
    endfunction

    task automatic model_step(input bit p1, input bit p2, input bit pz, input bit c, input bit r);
        bit own;
        if (!r || c) begin
            m_st = 0; m_pre = 0; m_t1 = SM * 60; m_t2 = SM * 60;
            m_f1 = 0; m_f2 = 0; m_res = 1;
        end else if (m_st == 0) begin
            if (p1 && !p2) begin m_st = 2; m_pre = 0; end
            else if (p2 && !p1) begin m_st = 1; m_pre = 0; end
        end else if (m_st == 1 || m_st == 2) begin
            own = (m_st == 1) ? p1 : p2;
            if (m_pre == HZ - 1) begin
                m_pre = 0;
                if (m_st == 1) m_t1--; else m_t2--;
                if (m_st == 1 && m_t1 == 0) begin m_f1 = 1; m_st = 4; return; end
                if (m_st == 2 && m_t2 == 0) begin m_f2 = 1; m_st = 4; return; end
            end else begin
                m_pre++;
            end
            if (own) begin
                m_st = (m_st == 1) ? 2 : 1;
                m_pre = 0;
            end else if (pz) begin
                m_res = m_st;
                m_st = 3;
            end
        end else if (m_st == 3) begin
            if (pz) m_st = m_res;
        end
    endtask

    int step_no = 0;

    task automatic step(input bit p1, input bit p2, input bit pz, input bit c, input bit r);
        logic [31:0] e;
        btn_p1 = p1; btn_p2 = p2; btn_pause = pz; clr = c; rst_n = r;
        model_step(p1, p2, pz, c, r);
        exp_q.push_back(model_pack());
        @(posedge clk);
        #1;
        btn_p1 = 0; btn_p2 = 0; btn_pause = 0; clr = 0; rst_n = 1;
        e = exp_q.pop_front();
        step_no++;
        check($sformatf("sb_step%0d", step_no), dut_pack(), e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
    endtask

    initial begin
        bit found;
        rst_n = 0; btn_p1 = 0; btn_p2 = 0; btn_pause = 0; clr = 0;
        #1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("reset_state", dut_pack(), RELOADED);

        // IDLE ignores both-buttons and pause
        step(1, 1, 0, 0, 1);
        check("idle_both_btn", 32'(active), 32'd0);
        step(0, 0, 1, 0, 1);
        check("idle_pause", 32'(paused), 32'd0);

        // start P1, first tick after four cycles
        step(0, 1, 0, 0, 1);
        check("start_p1", 32'(active), 32'b01);
        idle(3);
        check("p1_pre_tick", {20'b0, min1, seg1}, {20'b0, 6'd1, 6'd0});
        idle(1);
        check("p1_first_tick", {8'b0, min1, seg1, min2, seg2}, {8'b0, 6'd0, 6'd59, 6'd1, 6'd0});

        // switch two cycles into the prescaler; P2's count starts from zero
        idle(2);
        step(1, 0, 0, 0, 1);
        check("switch_to_p2", 32'(active), 32'b10);
        idle(3);
        check("p2_pre_tick", {20'b0, min2, seg2}, {20'b0, 6'd1, 6'd0});
        idle(1);
        check("p2_first_tick", {20'b0, min2, seg2, seg1}, {20'b0, 6'd0, 6'd59, 6'd59});

        // pause/resume keeps the held prescaler value
        idle(2);
        step(0, 0, 1, 0, 1);
        check("pause_enter", {30'b0, paused, active == 2'b00}, 32'b11);
        idle(20);
        check("pause_hold", {24'b0, seg2, paused, 1'b0}, {24'b0, 6'd59, 1'b1, 1'b0});
        step(0, 0, 1, 0, 1);
        check("pause_resume", {29'b0, active, paused}, {29'b0, 2'b10, 1'b0});
        idle(1);
        check("resume_tick", 32'(seg2), 32'd58);

        // full run-down of P1 to the flag
        step(0, 0, 0, 1, 1);
        check("clr_reload", dut_pack(), RELOADED);
        step(0, 1, 0, 0, 1);
        idle(240);
        check("p1_flag", {4'b0, min1, seg1, min2, seg2, active, paused, flag1, flag2},
              {4'b0, 6'd0, 6'd0, 6'd1, 6'd0, 2'b00, 1'b0, 1'b1, 1'b0});
        step(1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        check("flag_frozen", {28'b0, active, paused, flag1}, {28'b0, 2'b00, 1'b0, 1'b1});
        step(0, 0, 0, 1, 1);
        check("flag_clr", dut_pack(), RELOADED);

        // switch on the tick that reaches 0:00 is discarded
        step(0, 1, 0, 0, 1);
        found = 0;
        for (int i = 0; i < 400; i++) begin
            if (m_st == 1 && m_t1 == 1 && m_pre == HZ - 1) begin
                found = 1;
                break;
            end
            idle(1);
        end
        check("tick_search", 32'(found), 32'd1);
        step(1, 0, 0, 0, 1);
        check("tick_switch_flag", {29'b0, active, flag1}, {29'b0, 2'b00, 1'b1});

        // reset mid-run
        step(0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 1);
        idle(6);
        step(0, 0, 0, 0, 0);
        check("rst_mid_run", dut_pack(), RELOADED);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
